// File: rtl/hazard_track_pkg.sv
// hazard_track_pkg: forwarding-select encoding, Tuse "unused" marker and default Tnew per result class
package hazard_track_pkg;

    // Forwarding select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    // Tuse value marking an operand the instruction does not read (for the default TW = 2)
    localparam logic [1:0] TUSE_UNUSED = 2'b11;

    // Tnew an instruction carries on entering E, by where its result is produced
    typedef enum logic [1:0] {
        TNEW_PC  = 2'd0,
        TNEW_ALU = 2'd1,
        TNEW_DM  = 2'd2
    } tnew_class_e;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-match hazard and forwarding-source selection for one decode operand
module hazard_match import hazard_track_pkg::*; #(
    parameter int STAGES = 3,
    parameter int REGW   = 5,
    parameter int TW     = 2,
    localparam int SW    = $clog2(STAGES + 1)
) (
    input  logic [REGW-1:0]        addr,
    input  logic [TW-1:0]          tuse,
    input  logic [STAGES*REGW-1:0] a3_s,
    input  logic [STAGES*TW-1:0]   tnew_s,
    output logic                   hazard,
    output logic [SW-1:0]          fwd_sel
);

    logic          hit;
    logic          used;
    logic [TW-1:0] hit_tnew;
    logic [SW-1:0] hit_k;

    // Scan oldest to youngest so the youngest match overwrites (older writers are shadowed)
    always_comb begin
        hit      = 1'b0;
        hit_tnew = '0;
        hit_k    = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (addr != '0 && a3_s[(k-1)*REGW +: REGW] == addr) begin
                hit      = 1'b1;
                hit_tnew = tnew_s[(k-1)*TW +: TW];
                hit_k    = SW'(k);
            end
        end
        used    = tuse != {TW{1'b1}};
        hazard  = hit && used && hit_tnew > tuse;
        fwd_sel = (hit && used && hit_tnew == '0) ? hit_k : SW'(FWD_RF);
    end

endmodule

// File: rtl/hazard_track.sv
// hazard_track: in-flight writer tracking, decode stall and operand forwarding selects.
// Define HAZARD_MDU_EN to add the mult/div busy counter and HI/LO structural stall.
module hazard_track import hazard_track_pkg::*; #(
    parameter int STAGES  = 3,
    parameter int REGW    = 5,
    parameter int TW      = 2,
    parameter int MDU_LAT = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REGW-1:0]              a1_d,
    input  logic [REGW-1:0]              a2_d,
    input  logic [TW-1:0]                tuse_rs_d,
    input  logic [TW-1:0]                tuse_rt_d,
    input  logic [REGW-1:0]              a3_d,
    input  logic [TW-1:0]                tnew_d,
    input  logic                         md_start_d,
    input  logic                         md_use_d,
    output logic                         stall,
    output logic [$clog2(STAGES+1)-1:0]  fwd_rs_sel,
    output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel,
    output logic [STAGES*REGW-1:0]       a3_s,
    output logic                         md_busy
);

    logic [STAGES-1:0][REGW-1:0] a3_pipe_q, a3_pipe_d;
    logic [STAGES-1:0][TW-1:0]   tnew_pipe_q, tnew_pipe_d;
    logic                        hz_rs, hz_rt, md_stall;

    hazard_match #(.STAGES(STAGES), .REGW(REGW), .TW(TW)) u_rs (
        .addr    (a1_d),
        .tuse    (tuse_rs_d),
        .a3_s    (a3_pipe_q),
        .tnew_s  (tnew_pipe_q),
        .hazard  (hz_rs),
        .fwd_sel (fwd_rs_sel)
    );

    hazard_match #(.STAGES(STAGES), .REGW(REGW), .TW(TW)) u_rt (
        .addr    (a2_d),
        .tuse    (tuse_rt_d),
        .a3_s    (a3_pipe_q),
        .tnew_s  (tnew_pipe_q),
        .hazard  (hz_rt),
        .fwd_sel (fwd_rt_sel)
    );

    assign stall = hz_rs | hz_rt | md_stall;
    assign a3_s  = a3_pipe_q;

    // Stage 1 takes the decode writer or a bubble; later stages age Tnew toward 0
    always_comb begin
        a3_pipe_d[0]   = stall ? '0 : a3_d;
        tnew_pipe_d[0] = stall ? '0 : tnew_d;
        for (int k = 1; k < STAGES; k++) begin
            a3_pipe_d[k]   = a3_pipe_q[k-1];
            tnew_pipe_d[k] = (tnew_pipe_q[k-1] == '0) ? '0 : tnew_pipe_q[k-1] - 1'b1;
        end
    end

    // Writer pipeline registers; reset drops all in-flight writers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a3_pipe_q   <= '0;
            tnew_pipe_q <= '0;
        end else begin
            a3_pipe_q   <= a3_pipe_d;
            tnew_pipe_q <= tnew_pipe_d;
        end
    end

`ifdef HAZARD_MDU_EN
    localparam int CW = $clog2(MDU_LAT + 1);

    logic          md_s1_q, md_s1_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    // A start counts once it reaches E; the counter reloads then and drains afterwards
    always_comb begin
        md_s1_d  = md_start_d & ~stall;
        md_cnt_d = md_s1_q ? CW'(MDU_LAT) : ((md_cnt_q != '0) ? md_cnt_q - 1'b1 : '0);
    end

    // Mult/div busy state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_s1_q  <= 1'b0;
            md_cnt_q <= '0;
        end else begin
            md_s1_q  <= md_s1_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy  = md_cnt_q != '0 || md_s1_q;
    assign md_stall = md_use_d & md_busy;
`else
    logic md_unused;
    assign md_unused = ^{md_start_d, md_use_d, MDU_LAT[0]};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule
